rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the single write port of the 8 x 32-bit register file between two writeback sources.
- Source A: ALU/execute result.
- Source B: load/multicycle result.
Each source has a valid/ready handshake and a one-entry holding register. Round-robin arbitration drives a registered write port (rf_wa/rf_wd/rf_we). A pending-write scoreboard reports read-after-write hazards for the two read addresses.

Parameters:
- DATA_W, 32, width of write data and holding registers.
- ADDR_W, 3, register address width; NREG = 2**ADDR_W = 8 scoreboard bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- n_rst  input  1  asynchronous active-low reset.
- a_valid  input  1  source A write request.
- a_ready  output  1  source A accept.
- a_addr  input  ADDR_W  source A destination register.
- a_data  input  DATA_W  source A write data.
- b_valid  input  1  source B write request.
- b_ready  output  1  source B accept.
- b_addr  input  ADDR_W  source B destination register.
- b_data  input  DATA_W  source B write data.
- rsv_valid  input  1  reserve destination register (issue-time).
- rsv_addr  input  ADDR_W  register to reserve.
- ra1  input  ADDR_W  read address 1 hazard query.
- ra2  input  ADDR_W  read address 2 hazard query.
- busy1  output  1  ra1 has a pending write.
- busy2  output  1  ra2 has a pending write.
- rf_wa  output  ADDR_W  register-file write address (registered).
- rf_wd  output  DATA_W  register-file write data (registered).
- rf_we  output  1  register-file write enable (registered).

Behaviour:
- Reset (n_rst=0, asynchronous):
  - both holding registers empty, contents 0;
  - rr pointer = A;
  - pending[7:0] = 0;
  - rf_we = 0, rf_wa = 0, rf_wd = 0.
- Holding registers:
  - a_full/b_full set on a_valid&&a_ready (resp. B) at posedge; addr and data are captured.
  - a_ready = ~a_full | grant_a; likewise for B.
  - Accept and drain in the same cycle is allowed: the new entry replaces the drained one, giving full throughput.
- Arbitration (combinational, each cycle):
  - Only A full -> grant_a. Only B full -> grant_b. Neither -> no grant.
  - Both full -> grant the source indicated by the rr pointer. After any grant with both full, rr points to the other source.
  - A single-source grant leaves rr unchanged.
- Write stage (posedge):
  - Any grant -> rf_we <= 1, rf_wa/rf_wd <= granted entry, granted holding register cleared (unless refilled the same edge).
  - No grant -> rf_we <= 0; rf_wa/rf_wd hold.
- Latency:
  - Accept at edge E0 -> rf_we=1 after E1 (no contention) -> register file written at E2.
  - A loser waits exactly one extra cycle; there is no starvation.
- Same destination in both holding registers: writes occur in grant order. There is no merging or suppression.
- Scoreboard:
  - rsv_valid sets pending[rsv_addr] at posedge.
  - rf_we=1 clears pending[rf_wa] at posedge (the edge the register file writes).
  - Set and clear of the same address on the same edge -> set wins.
  - busy1 = pending[ra1], busy2 = pending[ra2], combinational.
- A write without a prior reservation is legal; the clear is a no-op.
- Reset mid-operation discards held entries and the in-flight rf_we immediately. The asynchronous drop of rf_we must not produce a register-file write.

Optional Feature:
Macro RF_WR_FWD_EN.
- Defined:
  - adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd1_data, fwd2_data (DATA_W);
  - fwdN_hit = rf_we && rf_wa==raN; fwdN_data = rf_wd;
  - busyN is forced to 0 when fwdN_hit, so a reader consumes the write-stage data in the cycle it is presented.
- Undefined: ports absent; busyN = pending[raN] only, and readers stall until after the write edge.

Test Plan:
- Reset, then a_valid with a_addr=3, a_data=0x11 for one cycle -> a_ready=1; rf_we=1, rf_wa=3, rf_wd=0x11 one cycle after the holding register fills; rf_we=0 next cycle.
- a_valid and b_valid both held for 4 cycles (A addr 1 data 0xA0+n, B addr 2 data 0xB0+n) -> rf writes alternate A,B,A,B,... with one write per cycle; each ready deasserts only while its entry waits.
- rsv_valid addr 5; ra1=5 -> busy1=1 until the edge where rf_we writes 5, then 0; reserving 5 on that same edge keeps busy1=1.
- b_valid held with a_valid idle -> B granted every cycle, b_ready stays 1, rr unchanged, 1 write/cycle.
- Assert n_rst=0 while both entries are full and rf_we=1 -> all outputs 0 immediately; after release, no stale write appears.
- With RF_WR_FWD_EN defined: reserve 6, write 6 data 0xDEAD, ra2=6 -> in the rf_we cycle fwd2_hit=1, fwd2_data=0xDEAD, busy2=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Two-source round-robin arbiter for the register-file write port, with a pending-write scoreboard.
// Optional RF_WR_FWD_EN adds write-stage forwarding outputs and masks busy on a forward hit.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we
`ifdef RF_WR_FWD_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    typedef enum logic {PtrA, PtrB} rr_e;

    logic              a_full, b_full;
    logic [ADDR_W-1:0] a_wa, b_wa;
    logic [DATA_W-1:0] a_wd, b_wd;
    rr_e               rr;
    logic [NREG-1:0]   pending, pending_nxt;
    logic              grant_a, grant_b;
    logic              a_take, b_take;

    always_comb begin
        grant_a = a_full && (!b_full || (rr == PtrA));
        grant_b = b_full && (!a_full || (rr == PtrB));
    end

    // A draining entry frees its slot in the same cycle, so a new request can land on that edge.
    assign a_ready = !a_full || grant_a;
    assign b_ready = !b_full || grant_b;
    assign a_take  = a_valid && a_ready;
    assign b_take  = b_valid && b_ready;

    // Set is applied after clear so a same-edge reserve wins.
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_wa] = 1'b0;
        end
        if (rsv_valid) begin
            pending_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_full  <= 1'b0;
            b_full  <= 1'b0;
            a_wa    <= '0;
            b_wa    <= '0;
            a_wd    <= '0;
            b_wd    <= '0;
            rr      <= PtrA;
            pending <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            if (a_take) begin
                a_full <= 1'b1;
                a_wa   <= a_addr;
                a_wd   <= a_data;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end

            if (b_take) begin
                b_full <= 1'b1;
                b_wa   <= b_addr;
                b_wd   <= b_data;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end

            // Pointer only moves on contended grants; a lone source never disturbs fairness.
            if (a_full && b_full) begin
                rr <= grant_a ? PtrB : PtrA;
            end

            rf_we <= grant_a || grant_b;
            if (grant_a) begin
                rf_wa <= a_wa;
                rf_wd <= a_wd;
            end else if (grant_b) begin
                rf_wa <= b_wa;
                rf_wd <= b_wd;
            end

            pending <= pending_nxt;
        end
    end

`ifdef RF_WR_FWD_EN
    assign fwd1_hit  = rf_we && (rf_wa == ra1);
    assign fwd2_hit  = rf_we && (rf_wa == ra2);
    assign fwd1_data = rf_wd;
    assign fwd2_data = rf_wd;
    assign busy1     = pending[ra1] && !fwd1_hit;
    assign busy2     = pending[ra2] && !fwd2_hit;
`else
    assign busy1 = pending[ra1];
    assign busy2 = pending[ra2];
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; forwarding checks are built when RF_WR_FWD_EN is defined.
module tb_rf_write_arbiter;

    logic        clk;
    logic        n_rst;
    logic        a_valid, b_valid, rsv_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr, rsv_addr, ra1, ra2;
    logic [31:0] a_data, b_data;
    logic        busy1, busy2;
    logic [2:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_we;
`ifdef RF_WR_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .rf_we     (rf_we)
`ifdef RF_WR_FWD_EN
        ,
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_ar;
        logic [9:0] exp_br;
        int na, nb, k;

        n_rst = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
        ra1 = 3'd5; ra2 = 3'd2;

        // Reset state
        #3;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_wa", 32'(rf_wa), 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        #4 n_rst = 1'b1;
        tick();

        // Single A write: visible one cycle after the holding register fills
        a_valid = 1'b1; a_addr = 3'd3; a_data = 32'h11;
        #1 check("t1_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        check("t1_we_early", 32'(rf_we), 32'd0);
        tick();
        check("t1_we", 32'(rf_we), 32'd1);
        check("t1_wa", 32'(rf_wa), 32'd3);
        check("t1_wd", rf_wd, 32'h11);
        tick();
        check("t1_we_off", 32'(rf_we), 32'd0);
        check("t1_wa_hold", 32'(rf_wa), 32'd3);

        // Both sources streaming four entries each: grants alternate A,B,...
        exp_ar = 10'b1110101011;
        exp_br = 10'b1101010101;
        na = 0; nb = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 2) begin
                check("t2_we_idle", 32'(rf_we), 32'd0);
            end else begin
                k = c - 2;
                check("t2_we", 32'(rf_we), 32'd1);
                check("t2_wa", 32'(rf_wa), (k % 2 == 0) ? 32'd1 : 32'd2);
                check("t2_wd", rf_wd, ((k % 2 == 0) ? 32'hA0 : 32'hB0) + 32'(k / 2));
            end
            a_valid = (na < 4); a_addr = 3'd1; a_data = 32'hA0 + 32'(na);
            b_valid = (nb < 4); b_addr = 3'd2; b_data = 32'hB0 + 32'(nb);
            #1;
            check("t2_a_ready", 32'(a_ready), 32'(exp_ar[c]));
            check("t2_b_ready", 32'(b_ready), 32'(exp_br[c]));
            if (a_valid && exp_ar[c]) na++;
            if (b_valid && exp_br[c]) nb++;
            tick();
        end
        check("t2_we_end", 32'(rf_we), 32'd0);

        // B alone: one write per cycle, b_ready stays high
        b_valid = 1'b1; b_addr = 3'd4; b_data = 32'hC0;
        #1 check("t3_b_ready0", 32'(b_ready), 32'd1);
        tick();
        check("t3_we0", 32'(rf_we), 32'd0);
        b_data = 32'hC1;
        #1 check("t3_b_ready1", 32'(b_ready), 32'd1);
        tick();
        check("t3_wd0", rf_wd, 32'hC0);
        check("t3_wa0", 32'(rf_wa), 32'd4);
        b_data = 32'hC2;
        #1 check("t3_b_ready2", 32'(b_ready), 32'd1);
        tick();
        check("t3_wd1", rf_wd, 32'hC1);
        b_valid = 1'b0;
        tick();
        check("t3_wd2", rf_wd, 32'hC2);
        check("t3_we2", 32'(rf_we), 32'd1);
        tick();
        check("t3_we_end", 32'(rf_we), 32'd0);

        // Pointer still on B (last contended grant was A): contention now grants B
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'h55;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 32'h66;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("t4_a_ready", 32'(a_ready), 32'd0);
        check("t4_b_ready", 32'(b_ready), 32'd1);
        tick();
        check("t4_wd_b", rf_wd, 32'h66);
        check("t4_wa_b", 32'(rf_wa), 32'd2);
        tick();
        check("t4_wd_a", rf_wd, 32'h55);
        check("t4_wa_a", 32'(rf_wa), 32'd1);
        tick();
        check("t4_we_end", 32'(rf_we), 32'd0);

        // Scoreboard: reserve 5, write it, re-reserve on the clearing edge
        ra1 = 3'd5; ra2 = 3'd2;
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        #1 check("t5_busy_pre", 32'(busy1), 32'd0);
        tick();
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_addr = 3'd5; a_data = 32'h77;
        #1 check("t5_busy_set", 32'(busy1), 32'd1);
        tick();
        a_valid = 1'b0;
        #1 check("t5_busy_held", 32'(busy1), 32'd1);
        tick();
        check("t5_we", 32'(rf_we), 32'd1);
        check("t5_wa", 32'(rf_wa), 32'd5);
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        #1;
        check("t5_busy_wcycle", 32'(busy1), FWD ? 32'd0 : 32'd1);
        check("t5_busy2", 32'(busy2), 32'd0);
        tick();
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_addr = 3'd5; a_data = 32'h78;
        #1 check("t5_set_wins", 32'(busy1), 32'd1);
        tick();
        a_valid = 1'b0;
        #1 check("t5_busy_again", 32'(busy1), 32'd1);
        tick();
        check("t5_wd2", rf_wd, 32'h78);
        #1 check("t5_busy_wcycle2", 32'(busy1), FWD ? 32'd0 : 32'd1);
        tick();
        check("t5_busy_clr", 32'(busy1), 32'd0);
        check("t5_we_end", 32'(rf_we), 32'd0);

        // Asynchronous reset with both entries full and a write in flight
        ra1 = 3'd4;
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        a_valid = 1'b1; a_addr = 3'd7; a_data = 32'h99;
        b_valid = 1'b1; b_addr = 3'd0; b_data = 32'hAA;
        tick();
        rsv_valid = 1'b0;
        a_data = 32'h9A;
        #1;
        check("t6_a_ready", 32'(a_ready), 32'd1);
        check("t6_b_ready", 32'(b_ready), 32'd0);
        check("t6_busy", 32'(busy1), 32'd1);
        tick();
        check("t6_we_inflight", 32'(rf_we), 32'd1);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("t6_rst_we", 32'(rf_we), 32'd0);
        check("t6_rst_wa", 32'(rf_wa), 32'd0);
        check("t6_rst_wd", rf_wd, 32'd0);
        check("t6_rst_busy", 32'(busy1), 32'd0);
        check("t6_rst_a_ready", 32'(a_ready), 32'd1);
        check("t6_rst_b_ready", 32'(b_ready), 32'd1);
        #2 n_rst = 1'b1;
        tick();
        check("t6_no_stale0", 32'(rf_we), 32'd0);
        tick();
        check("t6_no_stale1", 32'(rf_we), 32'd0);

        // Pointer back on A after reset
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 32'h2;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("t7_a_ready", 32'(a_ready), 32'd1);
        check("t7_b_ready", 32'(b_ready), 32'd0);
        tick();
        check("t7_wd_a", rf_wd, 32'h1);
        tick();
        check("t7_wd_b", rf_wd, 32'h2);
        tick();

`ifdef RF_WR_FWD_EN
        // Forwarding: reader of 6 sees data in the write-stage cycle
        ra2 = 3'd6;
        rsv_valid = 1'b1; rsv_addr = 3'd6;
        tick();
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_addr = 3'd6; a_data = 32'hDEAD;
        #1 check("t8_busy2_pend", 32'(busy2), 32'd1);
        tick();
        a_valid = 1'b0;
        tick();
        check("t8_fwd2_hit", 32'(fwd2_hit), 32'd1);
        check("t8_fwd2_data", fwd2_data, 32'hDEAD);
        check("t8_busy2", 32'(busy2), 32'd0);
        check("t8_fwd1_hit", 32'(fwd1_hit), 32'd0);
        tick();
        check("t8_fwd2_off", 32'(fwd2_hit), 32'd0);
        check("t8_busy2_clr", 32'(busy2), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
